// File: rtl/vga_pkg.sv
// Shared raster geometry, bus widths and scheduler state encoding.
// No logic; constants and types only.
// Backpressure: not applicable.
package vga_pkg;
    localparam int H_RES            = 160;
    localparam int V_RES            = 120;
    localparam int PIXELS_PER_FRAME = H_RES * V_RES;

    localparam int X_W      = 8;
    localparam int Y_W      = 7;
    localparam int ADDR_W   = 15;
    localparam int COLOUR_W = 3;

    localparam logic [X_W-1:0] X_LAST = X_W'(H_RES - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(V_RES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        FLUSH = 2'd2,
        HOLD  = 2'd3
    } state_t;
endpackage

// File: rtl/image_sweep_scheduler_if.sv
// Bundle between the sweep scheduler, the image ROM mux and the vga adapter.
// Wires only, no latency.
// No backpressure: the adapter accepts one plot per cycle unconditionally.
interface image_sweep_scheduler_if;
    logic                          second_pulse;
    logic                          freeze;
    logic [vga_pkg::COLOUR_W-1:0]  rom_data;
    logic [vga_pkg::ADDR_W-1:0]    rom_address;
    logic [1:0]                    rom_select;
    logic [vga_pkg::X_W-1:0]       x;
    logic [vga_pkg::Y_W-1:0]       y;
    logic [vga_pkg::COLOUR_W-1:0]  colour;
    logic                          plot;
    logic                          busy;
    logic                          frame_done;

    // Scheduler side.
    modport master (
        input  second_pulse, freeze, rom_data,
        output rom_address, rom_select, x, y, colour, plot, busy, frame_done
    );

    // Environment side: timebase, ROM and adapter.
    modport slave (
        output second_pulse, freeze, rom_data,
        input  rom_address, rom_select, x, y, colour, plot, busy, frame_done
    );
endinterface

// File: rtl/image_sweep_scheduler_pixel_sweep_counter.sv
// Raster walker: sx inner 0..159, sy outer 0..119, address = sy*160 + sx.
// Address is combinational from the counter registers (0 cycles after the count).
// No backpressure: advances on every enabled cycle, wraps to 0 after the last pixel.
module pixel_sweep_counter
    import vga_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              i_clr,
    input  logic              i_en,
    output logic [X_W-1:0]    o_sx,
    output logic [Y_W-1:0]    o_sy,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_last
);
    logic [X_W-1:0] r_sx;
    logic [Y_W-1:0] r_sy;
    logic           w_x_end;
    logic           w_y_end;

    assign w_x_end = (r_sx == X_LAST);
    assign w_y_end = (r_sy == Y_LAST);

    // Raster stepping: x inner loop, y advances on x wrap, whole raster wraps.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sx <= '0;
            r_sy <= '0;
        end else if (i_clr) begin
            r_sx <= '0;
            r_sy <= '0;
        end else if (i_en) begin
            if (w_x_end) begin
                r_sx <= '0;
                r_sy <= w_y_end ? '0 : r_sy + Y_W'(1);
            end else begin
                r_sx <= r_sx + X_W'(1);
            end
        end
    end

    // y*160 as y*128 + y*32 keeps this to two adders, no multiplier.
    assign o_addr = ADDR_W'({r_sy, 7'b0}) + ADDR_W'({r_sy, 5'b0}) + ADDR_W'(r_sx);
    assign o_sx   = r_sx;
    assign o_sy   = r_sy;
    assign o_last = w_x_end && w_y_end;
endmodule

// File: rtl/image_sweep_scheduler.sv
// Repaints the 160x120 framebuffer from one image ROM, dwells, then moves to the next image.
// Pixel reaches the adapter ROM_LATENCY cycles after its address; frame = 1 + 19200 + ROM_LATENCY cycles.
// No backpressure: one pixel per cycle; freeze only stalls the dwell count in HOLD.
module image_sweep_scheduler
    import vga_pkg::*;
#(
    parameter int NUM_IMAGES    = 3,
    parameter int DWELL_SECONDS = 10,
    parameter int ROM_LATENCY   = 1
) (
    input  logic                    clock,
    input  logic                    reset,
    image_sweep_scheduler_if.master bus
);
    localparam logic [1:0] IMG_LAST   = 2'(NUM_IMAGES - 1);
    localparam logic [3:0] DWELL_LAST = 4'(DWELL_SECONDS - 1);
    localparam logic       FLUSH_LAST = 1'(ROM_LATENCY - 1);

    state_t                r_state;
    logic [1:0]            r_img;
    logic [3:0]            r_dwell;
    logic                  r_flush;
    logic                  r_busy;
    logic                  r_done;
    logic [X_W-1:0]        r_px [ROM_LATENCY];
    logic [Y_W-1:0]        r_py [ROM_LATENCY];
    logic                  r_pv [ROM_LATENCY];
    logic [COLOUR_W-1:0]   r_colour;

    logic [X_W-1:0]        w_sx;
    logic [Y_W-1:0]        w_sy;
    logic [ADDR_W-1:0]     w_addr;
    logic                  w_last;
    logic                  w_col_vld;

    pixel_sweep_counter u_counter (
        .clock  (clock),
        .reset  (reset),
        .i_clr  (r_state == IDLE),
        .i_en   (r_state == SWEEP),
        .o_sx   (w_sx),
        .o_sy   (w_sy),
        .o_addr (w_addr),
        .o_last (w_last)
    );

    // Sequencer: IDLE -> SWEEP -> FLUSH -> HOLD -> IDLE, with busy/frame_done registered here.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_img   <= '0;
            r_dwell <= '0;
            r_flush <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_state <= SWEEP;
                    r_busy  <= 1'b1;
                end
                SWEEP: begin
                    if (w_last) begin
                        r_state <= FLUSH;
                        r_flush <= 1'b0;
                    end
                end
                FLUSH: begin
                    if (r_flush == FLUSH_LAST) begin
                        r_state <= HOLD;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_flush <= r_flush + 1'b1;
                    end
                end
                HOLD: begin
                    // A pulse that arrives while frozen is simply lost.
                    if (bus.second_pulse && !bus.freeze) begin
                        if (r_dwell == DWELL_LAST) begin
                            r_dwell <= '0;
                            r_img   <= (r_img == IMG_LAST) ? 2'd0 : r_img + 2'd1;
                            r_state <= IDLE;
                        end else begin
                            r_dwell <= r_dwell + 4'd1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Colour is sampled on the same edge that loads the final stage, so it pairs with its x/y.
    if (ROM_LATENCY == 1) begin : g_col_l1
        assign w_col_vld = (r_state == SWEEP);
    end else begin : g_col_ln
        assign w_col_vld = r_pv[ROM_LATENCY-2];
    end

    // Delay line carrying (sx, sy, valid) to line up with ROM read latency.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ROM_LATENCY; i++) begin
                r_px[i] <= '0;
                r_py[i] <= '0;
                r_pv[i] <= 1'b0;
            end
            r_colour <= '0;
        end else begin
            r_px[0] <= w_sx;
            r_py[0] <= w_sy;
            r_pv[0] <= (r_state == SWEEP);
            for (int i = 1; i < ROM_LATENCY; i++) begin
                r_px[i] <= r_px[i-1];
                r_py[i] <= r_py[i-1];
                r_pv[i] <= r_pv[i-1];
            end
            r_colour <= w_col_vld ? bus.rom_data : '0;
        end
    end

    assign bus.rom_address = w_addr;
    assign bus.rom_select  = r_img;
    assign bus.x           = r_px[ROM_LATENCY-1];
    assign bus.y           = r_py[ROM_LATENCY-1];
    assign bus.plot        = r_pv[ROM_LATENCY-1];
    assign bus.colour      = r_colour;
    assign bus.busy        = r_busy;
    assign bus.frame_done  = r_done;
endmodule

// File: tb/tb_image_sweep_scheduler.sv
// Bench: ROM returns addr[2:0]; every issued address pushes its expected pixel, every plot pops one.
// A second instance with two-cycle ROM latency checks first-frame timing.
module tb_image_sweep_scheduler;
    import vga_pkg::*;

    typedef struct packed {
        logic [X_W-1:0]      x;
        logic [Y_W-1:0]      y;
        logic [COLOUR_W-1:0] c;
    } pix_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic [COLOUR_W-1:0] rom2;

    int n_vec = 0;
    int n_err = 0;
    int run = 0;
    int last_run = 0;
    bit l2_done = 1'b0;
    pix_t exp_q[$];

    image_sweep_scheduler_if ifc ();
    image_sweep_scheduler_if ifc2 ();

    image_sweep_scheduler #(.NUM_IMAGES(3), .DWELL_SECONDS(10), .ROM_LATENCY(1)) u_dut (
        .clock (clock),
        .reset (reset),
        .bus   (ifc)
    );

    image_sweep_scheduler #(.NUM_IMAGES(3), .DWELL_SECONDS(10), .ROM_LATENCY(2)) u_dut_l2 (
        .clock (clock),
        .reset (reset),
        .bus   (ifc2)
    );

    always #5 clock = ~clock;

    // Single-cycle ROM: data read combinationally, sampled on the next edge.
    assign ifc.rom_data = ifc.rom_address[2:0];
    // Two-cycle ROM: one internal register stage.
    always @(posedge clock) rom2 <= ifc2.rom_address[2:0];
    assign ifc2.rom_data = rom2;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse(input logic frz);
        ifc.second_pulse = 1'b1;
        ifc.freeze       = frz;
        tick();
        ifc.second_pulse = 1'b0;
        ifc.freeze       = 1'b0;
    endtask

    // Called in the IDLE cycle; walks the whole frame or aborts with reset at pixel abort_at.
    task automatic sweep_frame(input logic [1:0] sel, input int inj_at, input int abort_at);
        pix_t e;
        last_run = 0;
        chk("idle_busy", ifc.busy, 0);
        chk("idle_sel", ifc.rom_select, sel);
        tick();
        for (int k = 0; k < PIXELS_PER_FRAME; k++) begin
            if (k == abort_at) begin
                reset = 1'b1;
                #1;
                chk("rst_plot", ifc.plot, 0);
                chk("rst_busy", ifc.busy, 0);
                chk("rst_addr", ifc.rom_address, 0);
                chk("rst_sel", ifc.rom_select, 0);
                chk("rst_xyc", {ifc.x, ifc.y, ifc.colour}, 0);
                chk("rst_done", ifc.frame_done, 0);
                exp_q.delete();
                repeat (2) tick();
                chk("rst_plot_held", ifc.plot, 0);
                reset = 1'b0;
                return;
            end
            ifc.second_pulse = (k == inj_at);
            ifc.freeze       = (k == inj_at + 1);
            chk("rom_address", ifc.rom_address, k);
            chk("sweep_busy", ifc.busy, 1);
            if (k == 0 || k == PIXELS_PER_FRAME - 1) chk("sweep_sel", ifc.rom_select, sel);
            e.x = X_W'(k % H_RES);
            e.y = Y_W'(k / H_RES);
            e.c = k[2:0];
            exp_q.push_back(e);
            tick();
        end
        ifc.second_pulse = 1'b0;
        ifc.freeze       = 1'b0;
        chk("flush_busy", ifc.busy, 1);
        chk("flush_done", ifc.frame_done, 0);
        tick();
        chk("hold_done", ifc.frame_done, 1);
        chk("hold_busy", ifc.busy, 0);
        chk("hold_plot", ifc.plot, 0);
        chk("hold_q_empty", exp_q.size(), 0);
        tick();
        chk("done_width", ifc.frame_done, 0);
        chk("plot_run", last_run, PIXELS_PER_FRAME);
    endtask

    // In HOLD: optional frozen pulses, 9 live pulses (no advance), then the 10th advances.
    task automatic dwell(input logic [1:0] cur, input logic [1:0] nxt, input int frozen);
        for (int i = 0; i < frozen; i++) begin
            pulse(1'b1);
            repeat (3) tick();
        end
        for (int i = 0; i < 9; i++) begin
            pulse(1'b0);
            repeat (3) tick();
        end
        chk("no_adv_sel", ifc.rom_select, cur);
        chk("no_adv_busy", ifc.busy, 0);
        pulse(1'b0);
        chk("adv_sel", ifc.rom_select, nxt);
    endtask

    // Plot-side scoreboard for the single-latency instance.
    initial begin
        pix_t p;
        forever begin
            @(posedge clock);
            #2;
            if (ifc.plot) begin
                run++;
                if (exp_q.size() == 0) begin
                    chk("spurious_plot", ifc.plot, 0);
                end else begin
                    p = exp_q.pop_front();
                    chk("pixel", {ifc.x, ifc.y, ifc.colour}, p);
                end
            end else if (run != 0) begin
                last_run = run;
                run = 0;
            end
        end
    end

    // Two-cycle latency instance: first frame timing after reset release.
    initial begin
        int c = 0;
        int busy_cyc = -1;
        int first_plot = -1;
        int np = 0;
        pix_t last_pix = '0;
        ifc2.second_pulse = 1'b0;
        ifc2.freeze       = 1'b0;
        @(negedge reset);
        while (c < 25000) begin
            @(posedge clock);
            #1;
            c++;
            if (ifc2.busy && busy_cyc < 0) busy_cyc = c;
            if (ifc2.plot) begin
                np++;
                if (first_plot < 0) begin
                    first_plot = c;
                    chk("l2_first_pix", {ifc2.x, ifc2.y, ifc2.colour}, 0);
                end
                last_pix = {ifc2.x, ifc2.y, ifc2.colour};
            end
            if (ifc2.frame_done) break;
        end
        chk("l2_busy_rise", busy_cyc, 1);
        chk("l2_first_plot", first_plot, 3);
        chk("l2_period", c, 1 + PIXELS_PER_FRAME + 2);
        chk("l2_plots", np, PIXELS_PER_FRAME);
        chk("l2_last_pix", last_pix, {8'd159, 7'd119, 3'd7});
        l2_done = 1'b1;
    end

    initial begin
        ifc.second_pulse = 1'b0;
        ifc.freeze       = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk("reset_plot", ifc.plot, 0);
        chk("reset_busy", ifc.busy, 0);
        chk("reset_addr", ifc.rom_address, 0);
        chk("reset_sel", ifc.rom_select, 0);
        chk("reset_xyc", {ifc.x, ifc.y, ifc.colour}, 0);
        chk("reset_done", ifc.frame_done, 0);
        reset = 1'b0;

        sweep_frame(2'd0, -1, -1);
        dwell(2'd0, 2'd1, 0);
        sweep_frame(2'd1, -1, 5000);
        sweep_frame(2'd0, 3000, -1);
        dwell(2'd0, 2'd1, 5);
        sweep_frame(2'd1, -1, -1);
        dwell(2'd1, 2'd2, 0);
        sweep_frame(2'd2, -1, -1);
        dwell(2'd2, 2'd0, 0);

        for (int i = 0; i < 100 && !l2_done; i++) tick();
        chk("l2_complete", l2_done, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/image_sweep_scheduler.md
Name: image_sweep_scheduler

Overview:
- Sequences the 160x120 framebuffer repaint for the screensaver display.
- Walks every pixel of one stored image, issues ROM addresses, and drives colour/x/y/plot into vga_adapter with ROM latency compensated.
- After a full frame it dwells for a set number of one-second pulses, then advances to the next image, wrapping around.
- Replaces the free-running x/y counters and the separate screensaver state counter with one controller.

Parameters:
- H_RES, 160, pixels per line; x width 8.
- V_RES, 120, lines per frame; y width 7.
- NUM_IMAGES, 3, number of image ROMs; legal range 1..4.
- DWELL_SECONDS, 10, second_pulse events counted in HOLD before advancing; legal range 1..15.
- ROM_LATENCY, 1, clock cycles from rom_address to valid rom_data; legal values 1 or 2.

Ports:
- clock, input, 1, system clock.
- reset, input, 1, asynchronous, active-high; clears all state.
- second_pulse, input, 1, one-cycle strobe once per second.
- freeze, input, 1, while high, the HOLD dwell count does not advance.
- rom_data, input, 3, colour from the ROM selected by rom_select; valid ROM_LATENCY cycles after the address.
- rom_address, output, 15, pixel address = y*160 + x.
- rom_select, output, 2, index of the image being painted; external mux uses it.
- x, output, 8, plot column.
- y, output, 7, plot row.
- colour, output, 3, pixel colour to the adapter.
- plot, output, 1, write enable to the adapter.
- busy, output, 1, high in SWEEP and FLUSH.
- frame_done, output, 1, one-cycle pulse when a frame completes.

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, image index 0, dwell count 0, pipeline valid bits 0.
- IDLE: lasts 1 cycle, then goes to SWEEP. Sweep counters are cleared.
- SWEEP: one address per cycle.
  - rom_address = {sy,7'b0} + {sy,5'b0} + sx, in 15-bit arithmetic.
  - sx counts 0..159 as the inner loop; sy counts 0..119 as the outer loop.
  - After issuing sx=159, sy=119 (address 19199), go to FLUSH.
- Delay pipeline: (sx, sy, valid) is delayed by ROM_LATENCY stages.
  - x, y and plot come from the last stage.
  - colour = rom_data, registered alongside the pipeline stage so colour lands in the same cycle as its x/y.
  - plot is high for exactly 19200 cycles per frame, contiguous, no gaps.
- FLUSH: lasts ROM_LATENCY cycles, draining the pipeline.
  - The last plot (x=159, y=119) occurs in the final FLUSH cycle.
  - The next cycle enters HOLD with a frame_done pulse.
- HOLD: plot=0, busy=0.
  - Each second_pulse with freeze=0 increments the dwell count.
  - When the count reaches DWELL_SECONDS: clear it, image index = (index==NUM_IMAGES-1) ? 0 : index+1, go to IDLE.
  - second_pulse while freeze=1 is dropped, not queued.
- rom_select equals the image index. It changes only on the HOLD->IDLE transition, so it is stable for the whole sweep plus flush.
- Events outside HOLD: second_pulse in IDLE/SWEEP/FLUSH is ignored; freeze in SWEEP/FLUSH is ignored, so a frame always completes once started.
- Reset mid-operation: asynchronous return to the reset values; the in-flight frame is abandoned with no further plot. After release, the FSM restarts from image 0.
- No combinational path from inputs to outputs except through registers.
- Frame period (cycles, IDLE to HOLD entry) = 1 + 19200 + ROM_LATENCY.

Decomposition:
- Shared package vga_pkg holds:
  - H_RES, V_RES and PIXELS_PER_FRAME=19200.
  - X_W=8, Y_W=7, ADDR_W=15, COLOUR_W=3.
  - State enum {IDLE, SWEEP, FLUSH, HOLD}.
- One sub-module, pixel_sweep_counter, contains the sx/sy raster counters, the address computation, and a last_pixel flag.
- The delay pipeline and FSM stay in image_sweep_scheduler.

Test Plan:
- Reset, then release with ROM_LATENCY=1 -> IDLE 1 cycle; rom_address=0 in the next cycle; first plot one cycle later with x=0, y=0, colour equal to the ROM word at address 0.
- Full frame with ROM model colour=addr[2:0] -> plot high for exactly 19200 consecutive cycles; last plot x=159, y=119, colour=7; frame_done pulses 1 cycle later; busy falls with it.
- HOLD with 10 second_pulses -> rom_select goes 0->1 after the 10th pulse, and a new sweep starts; 9 pulses -> no advance.
- Three dwell cycles -> rom_select sequence 0, 1, 2, 0 (wrap); with ROM_LATENCY=2 the frame period is 19203 cycles.
- In HOLD, freeze=1 for 5 pulses, then freeze=0 for 10 pulses -> advance only after the 10th unfrozen pulse; second_pulse during SWEEP does not change the dwell count.
- Assert reset at pixel 5000 of image 1 -> plot drops immediately, all outputs 0; after release, the sweep restarts at address 0 with rom_select=0.
